jk_reg_counter: RTL and testbench
=================================

// Module: jk_reg_counter
// PURPOSE
//   WIDTH-bit register bank of JK flip-flops with shared clock and clear.
//   Adds parallel load and up/down counting modes on top of the per-bit JK behaviour.
//   Provides a terminal-count flag and a change pulse.
//   Used as a general state/count register in sequential datapaths
//   (event counters, flag banks, small timers).
// PARAMETERS
//   WIDTH     8   number of flip-flops (>=1)
//   SATURATE  0   0: count wraps at bounds; 1: count holds at all-ones (up) / zero (down)
//   RESET_VAL 0   WIDTH-bit value loaded into q on clear
// PORTS
//   clk    in   1      rising-edge clock, sole clock domain
//   clear  in   1      synchronous reset, active-low; sampled on posedge clk only
//   en     in   1      update enable; 0 = hold all state
//   mode   in   2      00 JK, 01 LOAD, 10 UP, 11 DOWN
//   j      in   WIDTH  per-bit J input (mode JK)
//   k      in   WIDTH  per-bit K input (mode JK)
//   d      in   WIDTH  parallel load data (mode LOAD)
//   q      out  WIDTH  register state
//   qbar   out  WIDTH  bitwise complement of q; registered alongside q
//   tc     out  1      terminal count: combinational from q, mode, en
//   chg    out  1      registered pulse: q changed on the previous edge
// BEHAVIOUR
//   - All state updates occur on posedge clk. There is no asynchronous path.
//   - Priority: clear == 0 > en == 0 > mode.
//   - Clear (clear == 0 at an edge):
//       q <= RESET_VAL; qbar <= ~RESET_VAL; chg <= 0.
//       Overrides en/mode/j/k/d in the same cycle.
//   - en == 0: q and qbar hold; chg <= 0.
//   - en == 1, mode JK: each bit i independently, per {j[i],k[i]}:
//       00 hold, 01 q[i]<=0, 10 q[i]<=1, 11 q[i]<=~q[i].
//   - en == 1, mode LOAD: q <= d.
//   - en == 1, mode UP: q <= q + 1 (modulo 2^WIDTH).
//       At q == all-ones: next q is 0 if SATURATE == 0; q holds if SATURATE == 1.
//   - en == 1, mode DOWN: q <= q - 1.
//       At q == 0: next q is all-ones if SATURATE == 0; q holds if SATURATE == 1.
//   - qbar always equals ~q after every edge; it never diverges, including after clear.
//   - Latency: one cycle from input sample to q/qbar; no pipelining.
//   - tc = en & ((mode == UP & q == all-ones) | (mode == DOWN & q == 0)).
//       tc is low in JK and LOAD modes.
//       tc flags that the next enabled edge wraps or saturates.
//   - chg <= (next q != current q) for an enabled, non-clear edge; otherwise 0.
//       chg is high for exactly one cycle per actual change.
//       A saturating hold, or JK 00 on all bits, gives chg = 0.
//   - Mode changes take effect on the same edge, with no idle cycle.
//       Clear asserted mid-count aborts the count at that edge.
//   - WIDTH == 1 is legal: UP and DOWN both toggle when SATURATE == 0.
// TESTING
//   1. clear=0 for 2 edges, WIDTH=8, RESET_VAL=8'h5A
//        -> q=8'h5A, qbar=8'hA5, chg=0, regardless of en/mode/j/k.
//   2. mode JK, q=8'h0F, j=8'hF0, k=8'h3C
//        -> q=8'hF3 (bits 7:6 set, 5:4 toggle, 3:2 reset, 1:0 hold), chg=1 next cycle.
//   3. LOAD d=8'hFE, then UP x2, SATURATE=0
//        -> q=FE, FF (tc=1 while FF), 00; chg pulses each edge.
//   4. SATURATE=1, DOWN from q=8'h01 for 3 edges
//        -> q=00, 00, 00; tc=1 at q=00; chg=1 after first edge only.
//   5. UP counting with en toggling 1,0,1 from q=8'h10
//        -> q=11, 11, 12; chg=1, 0, 1; qbar tracks ~q every cycle.
//   6. clear=0 asserted during UP count at q=8'h33 with en=1
//        -> next q=RESET_VAL, chg=0; counting resumes from RESET_VAL after clear=1.

Source files
------------

// File: rtl/jk_reg_counter.sv
// Purpose: WIDTH-bit JK flip-flop bank with parallel load, up/down counting, terminal count and change pulse.
// Latency: one cycle from input sample to q/qbar/chg; tc is combinational from q, mode and en.
// Backpressure: none; en=0 stalls all state, and a synchronous active-low clear overrides everything.
module jk_reg_counter #(
  parameter int               WIDTH     = 8,
  parameter bit               SATURATE  = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             chg
);

  localparam logic [1:0] MODE_JK   = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_UP   = 2'b10;
  localparam logic [1:0] MODE_DOWN = 2'b11;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic             at_max;
  logic             at_min;
  logic [WIDTH-1:0] q_nxt;

  assign at_max = (q == ALL_ONES);
  assign at_min = (q == '0);

  // Next value of the bank for an enabled, non-clear edge.
  always_comb begin
    q_nxt = q;
    case (mode)
      // Characteristic JK equation per bit: 00 hold, 01 reset, 10 set, 11 toggle.
      MODE_JK:   q_nxt = (j & ~q) | (~k & q);
      MODE_LOAD: q_nxt = d;
      MODE_UP:   q_nxt = (SATURATE && at_max) ? q : q + ONE;
      MODE_DOWN: q_nxt = (SATURATE && at_min) ? q : q - ONE;
      default:   q_nxt = q;
    endcase
  end

  // Warns that the next enabled edge will wrap or saturate.
  assign tc = en & (((mode == MODE_UP) & at_max) | ((mode == MODE_DOWN) & at_min));

  // State update: clear beats en, en beats mode; qbar is kept as the complement of q.
  always_ff @(posedge clk) begin
    if (!clear) begin
      q    <= RESET_VAL;
      qbar <= ~RESET_VAL;
      chg  <= 1'b0;
    end else if (!en) begin
      chg  <= 1'b0;
    end else begin
      q    <= q_nxt;
      qbar <= ~q_nxt;
      chg  <= (q_nxt != q);
    end
  end

endmodule

// File: tb/tb_jk_reg_counter.sv
// Bench for jk_reg_counter: a wrapping and a saturating instance share one stimulus stream.
// Each step pushes hand-computed expectations into a queue; a monitor pops and compares.
// tc is compared before the edge, q/qbar/chg after it.
module tb_jk_reg_counter;

  localparam logic [1:0] M_JK   = 2'b00;
  localparam logic [1:0] M_LOAD = 2'b01;
  localparam logic [1:0] M_UP   = 2'b10;
  localparam logic [1:0] M_DOWN = 2'b11;

  typedef struct packed {
    logic       chk_tc;
    logic       tc_w;
    logic       tc_s;
    logic [7:0] q_w;
    logic       chg_w;
    logic [7:0] q_s;
    logic       chg_s;
  } exp_t;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] j = '0;
  logic [7:0] k = '0;
  logic [7:0] d = '0;

  logic [7:0] q_w, qbar_w, q_s, qbar_s;
  logic       tc_w, chg_w, tc_s, chg_s;

  exp_t exp_q[$];
  logic step_vld = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   step_no = 0;

  always #5 clk = ~clk;

  jk_reg_counter #(.WIDTH(8), .SATURATE(1'b0), .RESET_VAL(8'h5A)) dut_w (
    .clk(clk), .clear(clear), .en(en), .mode(mode), .j(j), .k(k), .d(d),
    .q(q_w), .qbar(qbar_w), .tc(tc_w), .chg(chg_w)
  );

  jk_reg_counter #(.WIDTH(8), .SATURATE(1'b1), .RESET_VAL(8'h5A)) dut_s (
    .clk(clk), .clear(clear), .en(en), .mode(mode), .j(j), .k(k), .d(d),
    .q(q_s), .qbar(qbar_s), .tc(tc_s), .chg(chg_s)
  );

  task automatic check(input string name, input int stp, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, stp, act, req);
    end
  endtask

  // Apply one input vector at the falling edge and queue what both instances must show.
  task automatic step(input logic c, input logic e, input logic [1:0] m,
                      input logic [7:0] jv, input logic [7:0] kv, input logic [7:0] dv,
                      input logic ctc, input logic etc_w, input logic etc_s,
                      input logic [7:0] eq_w, input logic ech_w,
                      input logic [7:0] eq_s, input logic ech_s);
    exp_t x;
    @(negedge clk);
    clear = c; en = e; mode = m; j = jv; k = kv; d = dv;
    x.chk_tc = ctc; x.tc_w = etc_w; x.tc_s = etc_s;
    x.q_w = eq_w; x.chg_w = ech_w; x.q_s = eq_s; x.chg_s = ech_s;
    exp_q.push_back(x);
    step_vld = 1'b1;
  endtask

  // Monitor: tc while the vector is held, then registered outputs after the edge.
  initial begin
    exp_t x;
    int   stp;
    forever begin
      @(negedge clk);
      #2;
      if (step_vld && exp_q.size() > 0) begin
        x = exp_q.pop_front();
        stp = step_no;
        step_no++;
        if (x.chk_tc) begin
          check("tc_wrap", stp, {7'd0, tc_w}, {7'd0, x.tc_w});
          check("tc_sat",  stp, {7'd0, tc_s}, {7'd0, x.tc_s});
        end
        @(posedge clk);
        #1;
        check("q_wrap",    stp, q_w,    x.q_w);
        check("qbar_wrap", stp, qbar_w, ~x.q_w);
        check("chg_wrap",  stp, {7'd0, chg_w}, {7'd0, x.chg_w});
        check("q_sat",     stp, q_s,    x.q_s);
        check("qbar_sat",  stp, qbar_s, ~x.q_s);
        check("chg_sat",   stp, {7'd0, chg_s}, {7'd0, x.chg_s});
      end
    end
  end

  initial begin
    // Clear held for two edges with conflicting en/mode/j/k/d.
    step(0, 1, M_UP,   8'hFF, 8'hFF, 8'h00, 0, 0, 0, 8'h5A, 0, 8'h5A, 0);
    step(0, 0, M_LOAD, 8'h00, 8'h00, 8'h12, 1, 0, 0, 8'h5A, 0, 8'h5A, 0);
    // JK per-bit behaviour.
    step(1, 1, M_LOAD, 8'h00, 8'h00, 8'h0F, 1, 0, 0, 8'h0F, 1, 8'h0F, 1);
    step(1, 1, M_JK,   8'hF0, 8'h3C, 8'h00, 1, 0, 0, 8'hF3, 1, 8'hF3, 1);
    step(1, 1, M_JK,   8'h00, 8'h00, 8'h00, 1, 0, 0, 8'hF3, 0, 8'hF3, 0);
    // Load then count up across the top.
    step(1, 1, M_LOAD, 8'h00, 8'h00, 8'hFE, 1, 0, 0, 8'hFE, 1, 8'hFE, 1);
    step(1, 1, M_UP,   8'h00, 8'h00, 8'h00, 1, 0, 0, 8'hFF, 1, 8'hFF, 1);
    step(1, 1, M_UP,   8'h00, 8'h00, 8'h00, 1, 1, 1, 8'h00, 1, 8'hFF, 0);
    // Count down across zero.
    step(1, 1, M_LOAD, 8'h00, 8'h00, 8'h01, 1, 0, 0, 8'h01, 1, 8'h01, 1);
    step(1, 1, M_DOWN, 8'h00, 8'h00, 8'h00, 1, 0, 0, 8'h00, 1, 8'h00, 1);
    step(1, 1, M_DOWN, 8'h00, 8'h00, 8'h00, 1, 1, 1, 8'hFF, 1, 8'h00, 0);
    step(1, 1, M_DOWN, 8'h00, 8'h00, 8'h00, 1, 0, 1, 8'hFE, 1, 8'h00, 0);
    // Enable toggling during an up count.
    step(1, 1, M_LOAD, 8'h00, 8'h00, 8'h10, 1, 0, 0, 8'h10, 1, 8'h10, 1);
    step(1, 1, M_UP,   8'h00, 8'h00, 8'h00, 1, 0, 0, 8'h11, 1, 8'h11, 1);
    step(1, 0, M_UP,   8'h00, 8'h00, 8'h00, 1, 0, 0, 8'h11, 0, 8'h11, 0);
    step(1, 1, M_UP,   8'h00, 8'h00, 8'h00, 1, 0, 0, 8'h12, 1, 8'h12, 1);
    // Clear aborts a count, counting resumes from the reset value.
    step(1, 1, M_LOAD, 8'h00, 8'h00, 8'h32, 1, 0, 0, 8'h32, 1, 8'h32, 1);
    step(1, 1, M_UP,   8'h00, 8'h00, 8'h00, 1, 0, 0, 8'h33, 1, 8'h33, 1);
    step(0, 1, M_UP,   8'h00, 8'h00, 8'h00, 1, 0, 0, 8'h5A, 0, 8'h5A, 0);
    step(1, 1, M_UP,   8'h00, 8'h00, 8'h00, 1, 0, 0, 8'h5B, 1, 8'h5B, 1);
    // tc stays low outside UP/DOWN; reloading the same value is not a change.
    step(1, 1, M_LOAD, 8'h00, 8'h00, 8'hFF, 1, 0, 0, 8'hFF, 1, 8'hFF, 1);
    step(1, 1, M_JK,   8'h00, 8'h00, 8'h00, 1, 0, 0, 8'hFF, 0, 8'hFF, 0);
    step(1, 1, M_LOAD, 8'h00, 8'h00, 8'hFF, 1, 0, 0, 8'hFF, 0, 8'hFF, 0);
    step(1, 0, M_UP,   8'h00, 8'h00, 8'h00, 1, 0, 0, 8'hFF, 0, 8'hFF, 0);
    step(1, 1, M_UP,   8'h00, 8'h00, 8'h00, 1, 1, 1, 8'h00, 1, 8'hFF, 0);
    // JK toggle on every bit.
    step(1, 1, M_JK,   8'hFF, 8'hFF, 8'h00, 1, 0, 0, 8'hFF, 1, 8'h00, 1);
    @(negedge clk);
    step_vld = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
